// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 2-FF synchronized line, 16x-style oversampling,
// mid-cell bit sampling, parallel word out with parity and framing status.
`timescale 1ns/1ps
module uart_rx_deserializer #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int PARITY_ODD       = 0,
  parameter int OVERSAMPLE       = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       sample_tick,
  input  logic                                       serial_in,
  output logic [INPUT_DATA_WIDTH+PARITY_ENABLED-1:0] o_data,
  output logic                                       o_valid,
  output logic                                       o_parity_err,
  output logic                                       o_frame_err,
  output logic                                       o_busy
);

  localparam int FW = INPUT_DATA_WIDTH + PARITY_ENABLED;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(FW + 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FW - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   tick_cnt, tick_n;
  logic [BW-1:0]   bit_cnt, bit_n;
  logic [FW-1:0]   shift_reg, shift_n;
  logic [FW-1:0]   data_n;
  logic            valid_n, perr_n, ferr_n;
  logic            rx_meta, rx_s;

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      rx_meta      <= serial_in;
      rx_s         <= rx_meta;
      state        <= state_n;
      tick_cnt     <= tick_n;
      bit_cnt      <= bit_n;
      shift_reg    <= shift_n;
      o_data       <= data_n;
      o_valid      <= valid_n;
      o_parity_err <= perr_n;
      o_frame_err  <= ferr_n;
    end
  end

  // Everything holds unless a sample tick arrives; o_valid is a one-clock pulse.
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    data_n  = o_data;
    perr_n  = o_parity_err;
    ferr_n  = o_frame_err;
    valid_n = 1'b0;
    if (sample_tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick_cnt == HALF_TICK) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == LAST_TICK) begin
            shift_n = {rx_s, shift_reg[FW-1:1]};
            tick_n  = '0;
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state_n = STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == LAST_TICK) begin
            data_n  = shift_reg;
            perr_n  = (PARITY_ENABLED != 0) ? ((^shift_reg) ^ ODD_BIT) : 1'b0;
            ferr_n  = ~rx_s;
            valid_n = 1'b1;
            tick_n  = '0;
            state_n = rx_s ? IDLE : BREAK_WAIT;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        BREAK_WAIT: begin
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
